// File: rtl/universal_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : universal_shift_register
// Description : WIDTH-bit universal shift register with hold, parallel load,
//               serial shift left/right, single-bit rotates, clear, and a
//               multi-cycle burst rotate-left of up to WIDTH positions.
//               All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module universal_shift_register #(
    parameter int WIDTH = 8,   // register width, 2..32
    parameter int CNT_W = 4    // burst count width, 2**CNT_W must exceed WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CNT_W-1:0] amt,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    output logic [WIDTH-1:0] q_out,
    output logic             busy,
    output logic             done
);

    // ------------------------------------------------------------------------
    // Command encodings
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_mode_hold  = 3'b000;
    localparam logic [2:0] c_mode_load  = 3'b001;
    localparam logic [2:0] c_mode_shl   = 3'b010;
    localparam logic [2:0] c_mode_shr   = 3'b011;
    localparam logic [2:0] c_mode_rotl  = 3'b100;
    localparam logic [2:0] c_mode_rotr  = 3'b101;
    localparam logic [2:0] c_mode_burst = 3'b110;
    localparam logic [2:0] c_mode_clear = 3'b111;

    // WIDTH expressed in the burst counter's width; fits because 2**CNT_W > WIDTH.
    localparam logic [CNT_W-1:0] c_width_cnt = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_q;
    logic [CNT_W-1:0]   r_remaining;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic [CNT_W-1:0]   w_remaining_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    // Precomputed datapath candidates
    logic [WIDTH-1:0]   w_q_shl;
    logic [WIDTH-1:0]   w_q_shr;
    logic [WIDTH-1:0]   w_q_rotl;
    logic [WIDTH-1:0]   w_q_rotr;
    logic [CNT_W-1:0]   w_burst_len;

    assign w_q_shl  = {r_q[WIDTH-2:0], ser_in_r};
    assign w_q_shr  = {ser_in_l, r_q[WIDTH-1:1]};
    assign w_q_rotl = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
    assign w_q_rotr = {r_q[0], r_q[WIDTH-1:1]};

    // Oversized burst requests saturate at a full revolution.
    assign w_burst_len = (amt > c_width_cnt) ? c_width_cnt : amt;

    // State register: reset wins over everything, including a live burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_q         <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_q         <= w_q_nxt;
            r_remaining <= w_remaining_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_q_nxt         = r_q;
        w_remaining_nxt = r_remaining;
        w_done_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    case (mode)
                        c_mode_hold:  w_q_nxt = r_q;
                        c_mode_load:  w_q_nxt = data_in;
                        c_mode_shl:   w_q_nxt = w_q_shl;
                        c_mode_shr:   w_q_nxt = w_q_shr;
                        c_mode_rotl:  w_q_nxt = w_q_rotl;
                        c_mode_rotr:  w_q_nxt = w_q_rotr;
                        c_mode_burst: begin
                            // A zero-length burst completes immediately
                            // without ever reporting busy.
                            if (w_burst_len == '0) begin
                                w_done_nxt = 1'b1;
                            end else begin
                                w_state_nxt     = ST_BURST;
                                w_remaining_nxt = w_burst_len;
                            end
                        end
                        c_mode_clear: w_q_nxt = '0;
                        default:      w_q_nxt = r_q;
                    endcase
                end
            end

            ST_BURST: begin
                // Commands are dropped while bursting; one rotate per cycle.
                if (r_remaining == '0) begin
                    // Not reachable in normal operation; recover to IDLE.
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_q_nxt         = w_q_rotl;
                    w_remaining_nxt = r_remaining - c_cnt_one;
                    if (r_remaining == c_cnt_one) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt     = ST_IDLE;
                w_remaining_nxt = '0;
            end
        endcase

        // busy is registered so it tracks the state being entered.
        w_busy_nxt = (w_state_nxt == ST_BURST);
    end

    assign q_out = r_q;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_universal_shift_register
// Description : Scoreboard bench for universal_shift_register. A driver
//               issues one command per cycle and pushes the expected
//               post-edge outputs from a behavioural model; a monitor pops
//               and compares after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_universal_shift_register;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [2:0]    mode = 3'b000;
    logic [W-1:0]  data_in = '0;
    logic [CW-1:0] amt = '0;
    logic          ser_in_r = 1'b0;
    logic          ser_in_l = 1'b0;
    logic [W-1:0]  q_out;
    logic          busy;
    logic          done;

    universal_shift_register #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .data_in  (data_in),
        .amt      (amt),
        .ser_in_r (ser_in_r),
        .ser_in_l (ser_in_l),
        .q_out    (q_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] q;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state: value, and burst described by start value,
    // requested length and edges elapsed since acceptance.
    logic [W-1:0] m_q     = '0;
    logic [W-1:0] m_start = '0;
    int           m_len   = 0;
    int           m_k     = 0;

    function automatic logic [W-1:0] rot_left(input logic [W-1:0] v, input int k);
        logic [2*W-1:0] t;
        t = {v, v} << (k % W);
        return t[2*W-1:W];
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        exp_t e;
        logic d;
        int   n;
        d = 1'b0;
        if (rst) begin
            m_q   = '0;
            m_len = 0;
            m_k   = 0;
        end else if (m_len > 0) begin
            m_k = m_k + 1;
            m_q = rot_left(m_start, m_k);
            if (m_k == m_len) begin
                m_len = 0;
                d     = 1'b1;
            end
        end else if (en) begin
            case (mode)
                3'b001: m_q = data_in;
                3'b010: m_q = W'((m_q << 1) | W'(ser_in_r));
                3'b011: m_q = (m_q >> 1) | (W'(ser_in_l) << (W - 1));
                3'b100: m_q = rot_left(m_q, 1);
                3'b101: m_q = rot_left(m_q, W - 1);
                3'b110: begin
                    n = (int'(amt) > W) ? W : int'(amt);
                    if (n == 0) begin
                        d = 1'b1;
                    end else begin
                        m_len   = n;
                        m_k     = 0;
                        m_start = m_q;
                    end
                end
                3'b111: m_q = '0;
                default: ;
            endcase
        end
        e.q    = m_q;
        e.busy = (m_len > 0);
        e.done = d;
        sb.push_back(e);
    endtask

    // Drive one cycle of stimulus, record its expectation, return after the edge.
    task automatic cyc(input logic r, input logic e, input logic [2:0] md,
                       input logic [W-1:0] d, input logic [CW-1:0] a,
                       input logic sr, input logic sl);
        @(negedge clk);
        rst      = r;
        en       = e;
        mode     = md;
        data_in  = d;
        amt      = a;
        ser_in_r = sr;
        ser_in_l = sl;
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'b000, '0, '0, 1'b0, 1'b0);
    endtask

    // Direct comparison against a literal taken from the scenario description.
    task automatic check_lit(input string name, input logic [W-1:0] eq,
                             input logic eb, input logic ed);
        tests++;
        if (q_out !== eq || busy !== eb || done !== ed) begin
            fails++;
            $display("FAIL %s: got q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
                     name, q_out, busy, done, eq, eb, ed);
        end
    endtask

    // Monitor: compare outputs after every edge that has a pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                tests++;
                if (q_out !== e.q || busy !== e.busy || done !== e.done) begin
                    fails++;
                    $display("FAIL scoreboard t=%0t: got q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
                             $time, q_out, busy, done, e.q, e.busy, e.done);
                end
            end
        end
    end

    initial begin
        // Reset, then load on the very first released edge.
        cyc(1'b1, 1'b0, 3'b000, '0, '0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 3'b001, 8'hFF, '0, 1'b0, 1'b0);
        check_lit("reset", 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 3'b001, 8'hA5, '0, 1'b0, 1'b0);
        check_lit("load", 8'hA5, 1'b0, 1'b0);

        // Single-cycle shifts and rotates.
        cyc(1'b0, 1'b1, 3'b010, '0, '0, 1'b1, 1'b0);
        check_lit("shl", 8'h4B, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 3'b011, '0, '0, 1'b0, 1'b1);
        check_lit("shr", 8'hA5, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 3'b100, '0, '0, 1'b0, 1'b0);
        check_lit("rotl", 8'h4B, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 3'b101, '0, '0, 1'b0, 1'b0);
        check_lit("rotr", 8'hA5, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 3'b111, '0, '0, 1'b0, 1'b0);
        check_lit("clear", 8'h00, 1'b0, 1'b0);

        // en gating.
        cyc(1'b0, 1'b1, 3'b001, 8'h3C, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 3'b001, 8'hFF, '0, 1'b0, 1'b0);
        check_lit("en_gate", 8'h3C, 1'b0, 1'b0);

        // Burst of 3 with loads attempted while busy.
        cyc(1'b0, 1'b1, 3'b001, 8'h81, '0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 3'b110, '0, 4'd3, 1'b0, 1'b0);
        check_lit("burst_accept", 8'h81, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 3'b001, 8'hFF, '0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 3'b001, 8'hFF, '0, 1'b0, 1'b0);
        check_lit("burst_mid", 8'h06, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 3'b001, 8'hFF, '0, 1'b0, 1'b0);
        check_lit("burst3_done", 8'h0C, 1'b0, 1'b1);
        idle(1);
        check_lit("burst3_after", 8'h0C, 1'b0, 1'b0);

        // Zero-length burst.
        cyc(1'b0, 1'b1, 3'b110, '0, 4'd0, 1'b0, 1'b0);
        check_lit("burst0", 8'h0C, 1'b0, 1'b1);
        idle(1);
        check_lit("burst0_after", 8'h0C, 1'b0, 1'b0);

        // Oversized burst clamps to a full revolution.
        cyc(1'b0, 1'b1, 3'b110, '0, 4'd15, 1'b0, 1'b0);
        idle(7);
        check_lit("burst15_busy", 8'h06, 1'b1, 1'b0);
        idle(1);
        check_lit("burst15_done", 8'h0C, 1'b0, 1'b1);

        // Command accepted in the done cycle.
        cyc(1'b0, 1'b1, 3'b001, 8'h5A, '0, 1'b0, 1'b0);
        check_lit("load_on_done", 8'h5A, 1'b0, 1'b0);

        // Reset during a burst: no done afterwards.
        cyc(1'b0, 1'b1, 3'b001, 8'h01, '0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 3'b110, '0, 4'd5, 1'b0, 1'b0);
        idle(2);
        cyc(1'b1, 1'b1, 3'b001, 8'hFF, '0, 1'b0, 1'b0);
        check_lit("rst_mid_burst", 8'h00, 1'b0, 1'b0);
        idle(6);
        check_lit("rst_no_done", 8'h00, 1'b0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            logic [CW-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 15))
                                            : CW'($urandom_range(0, 4));
            cyc(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                3'($urandom_range(0, 7)),
                W'($urandom),
                a,
                1'($urandom),
                1'($urandom));
        end

        // Every issued expectation must have been consumed by the monitor.
        idle(2);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits; legal range 2..32.
REQ-002 SHALL have parameter CNT_W, default 4, burst amount width; SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 en  input  1  command strobe; mode sampled only when en=1.
REQ-006 mode  input  3  operation select (see Function).
REQ-007 data_in  input  WIDTH  parallel load value.
REQ-008 amt  input  CNT_W  burst rotate count.
REQ-009 ser_in_r  input  1  serial bit entering bit 0 on shift-left.
REQ-010 ser_in_l  input  1  serial bit entering bit WIDTH-1 on shift-right.
REQ-011 q_out  output  WIDTH  registered register contents.
REQ-012 busy  output  1  high while burst in progress.
REQ-013 done  output  1  one-cycle pulse on burst completion.

Function
REQ-014 States: IDLE, BURST; only IDLE accepts commands.
REQ-015 In IDLE with en=0: q_out holds; no other effect.
REQ-016 In IDLE with en=1, next edge applies mode:
- 000 hold: q unchanged.
- 001 load: q <= data_in.
- 010 shl: q <= {q[WIDTH-2:0], ser_in_r}.
- 011 shr: q <= {ser_in_l, q[WIDTH-1:1]}.
- 100 rotl: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
- 101 rotr: q <= {q[0], q[WIDTH-1:1]}.
- 110 burst rotl: enter BURST; remaining <= min(amt, WIDTH).
- 111 clear: q <= 0.
REQ-017 Single-cycle ops (000-101, 111): result visible on q_out the cycle after the accepting edge; busy stays 0; done stays 0.
REQ-018 Burst accept edge: busy=1 from the next cycle; q unchanged on the accept edge.
REQ-019 Each BURST cycle: q rotates left by one bit, remaining decrements; when remaining reaches 0, return to IDLE, busy=0, done=1 for exactly one cycle.
REQ-020 Burst of n (1<=n<=WIDTH): busy high exactly n cycles; q_out after completion = original rotated left by n; done asserted in the cycle after busy's last high cycle.
REQ-021 amt=0 with mode 110: no BURST entry; q unchanged; busy stays 0; done pulses one cycle after the accepting edge.
REQ-022 amt>WIDTH: clamped to WIDTH; final q_out equals pre-burst value.
REQ-023 During BURST: en, mode, data_in, ser_in_* ignored; commands are dropped, not queued.
REQ-024 Command may be accepted in the same cycle done=1 (block already IDLE).
REQ-025 No combinational path from inputs to any output.

Reset
REQ-026 rst=1 at an edge: q_out=0, busy=0, done=0, state=IDLE, remaining=0.
REQ-027 rst has priority over en and over any burst in progress; aborted burst produces no done pulse.
REQ-028 First command accepted at the first edge with rst=0.

Verification
REQ-029 Reset then load: rst 2 cycles, en=1 mode=001 data_in=0xA5 -> q_out=0xA5 next cycle, busy=0, done=0.
REQ-030 Shifts: q=0xA5; shl ser_in_r=1 -> 0x4B; shr ser_in_l=1 -> 0xA5; rotl -> 0x4B; rotr -> 0xA5; clear -> 0x00.
REQ-031 Hold/en gating: q=0x3C, en=0 with mode=001 data_in=0xFF for 5 cycles -> q_out stays 0x3C.
REQ-032 Burst: q=0x81, mode=110 amt=3 -> busy high 3 cycles, q_out=0x0C, done 1-cycle pulse; mode=001 data_in=0xFF asserted during busy ignored.
REQ-033 Burst corners: amt=0 -> q unchanged, done pulse, busy never high; amt=15 (WIDTH=8) -> busy 8 cycles, q_out unchanged.
REQ-034 Reset mid-burst: q=0x01, amt=5, rst after 2 busy cycles -> q_out=0, busy=0, no done pulse.
